// File: rtl/env_mixer2_pkg.sv
// Shared types and constants for the two-channel envelope mixer.
package env_mixer2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ATTACK  = 2'd1,
    ST_DECAY   = 2'd2,
    ST_SUSTAIN = 2'd3
  } env_state_e;

  localparam logic [7:0] SMP_MID = 8'd64;
  localparam logic [7:0] DAC_MID = 8'd128;

  localparam int DEF_TICK_DIV    = 1200;
  localparam int DEF_ATTACK_STEP = 8;
  localparam int DEF_DECAY_STEP  = 1;
  localparam int DEF_SUSTAIN_LVL = 160;

  // Signed sample times unsigned envelope, scaled by 1/256 with floor rounding.
  function automatic logic signed [7:0] env_scale(input logic signed [7:0] s,
                                                  input logic [7:0] env);
    logic signed [16:0] prod;
    logic signed [16:0] shifted;
    prod    = s * $signed({1'b0, env});
    shifted = prod >>> 8;
    return shifted[7:0];
  endfunction

endpackage

// File: rtl/env_mixer2_env_gen.sv
// Per-channel attack/decay/sustain envelope keyed by note-code changes.
module env_gen
  import env_mixer2_pkg::*;
#(
  parameter int ATTACK_STEP = DEF_ATTACK_STEP,
  parameter int DECAY_STEP  = DEF_DECAY_STEP,
  parameter int SUSTAIN_LVL = DEF_SUSTAIN_LVL
) (
  input  logic       clk12,
  input  logic       n_reset,
  input  logic [5:0] note,
  input  logic       tick,
  output logic [7:0] env,
  output logic [1:0] state
);

  localparam logic [8:0] ATT_INC = 9'(ATTACK_STEP);
  localparam logic [7:0] DEC_DEC = 8'(DECAY_STEP);
  localparam logic [7:0] SUS_LVL = 8'(SUSTAIN_LVL);

  env_state_e state_q, state_d;
  logic [7:0] env_q, env_d;
  logic [5:0] note_q;
  logic [8:0] att_sum;

  assign att_sum = {1'b0, env_q} + ATT_INC;

  always_ff @(posedge clk12 or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ST_IDLE;
      env_q   <= 8'd0;
      note_q  <= 6'd0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      note_q  <= note;
    end
  end

  // Mute beats trigger beats tick; a retrigger keeps the current level.
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (note == 6'd0) begin
      state_d = ST_IDLE;
      env_d   = 8'd0;
    end else if (note != note_q) begin
      state_d = ST_ATTACK;
    end else if (tick) begin
      case (state_q)
        ST_ATTACK: begin
          if (att_sum >= 9'd255) begin
            env_d   = 8'd255;
            state_d = ST_DECAY;
          end else begin
            env_d = att_sum[7:0];
          end
        end
        ST_DECAY: begin
          if (env_q <= SUS_LVL || (env_q - SUS_LVL) <= DEC_DEC) begin
            env_d   = SUS_LVL;
            state_d = ST_SUSTAIN;
          end else begin
            env_d = env_q - DEC_DEC;
          end
        end
        ST_IDLE:  env_d = 8'd0;
        default:  env_d = env_q;
      endcase
    end
  end

  assign env   = env_q;
  assign state = state_q;

endmodule

// File: rtl/env_mixer2.sv
// Two enveloped sine channels mixed into one unipolar DAC word, 3-cycle latency.
module env_mixer2
  import env_mixer2_pkg::*;
#(
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter int ATTACK_STEP = DEF_ATTACK_STEP,
  parameter int DECAY_STEP  = DEF_DECAY_STEP,
  parameter int SUSTAIN_LVL = DEF_SUSTAIN_LVL
) (
  input  logic       clk12,
  input  logic       n_reset,
  input  logic [5:0] note1,
  input  logic [5:0] note2,
  input  logic [7:0] smp1,
  input  logic [7:0] smp2,
  output logic [7:0] dac_out,
  output logic [7:0] env1,
  output logic [7:0] env2,
  output logic [1:0] st1,
  output logic [1:0] st2
);

  logic [15:0] count_q, count_d;
  logic        tick;

  assign tick    = (count_q == 16'(TICK_DIV - 1));
  assign count_d = tick ? 16'd0 : count_q + 16'd1;

  always_ff @(posedge clk12 or negedge n_reset) begin
    if (!n_reset) count_q <= 16'd0;
    else          count_q <= count_d;
  end

  logic [5:0]        note_w [2];
  logic [7:0]        smp_w  [2];
  logic [7:0]        env_w  [2];
  logic [1:0]        st_w   [2];
  logic signed [7:0] p_w    [2];

  assign note_w[0] = note1;
  assign note_w[1] = note2;
  assign smp_w[0]  = smp1;
  assign smp_w[1]  = smp2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic [6:0]        mag;
      logic signed [7:0] s_d, s_q, p_d, p_q;
      logic [7:0]        e_q;

      env_gen #(
        .ATTACK_STEP (ATTACK_STEP),
        .DECAY_STEP  (DECAY_STEP),
        .SUSTAIN_LVL (SUSTAIN_LVL)
      ) u_env (
        .clk12   (clk12),
        .n_reset (n_reset),
        .note    (note_w[gi]),
        .tick    (tick),
        .env     (env_w[gi]),
        .state   (st_w[gi])
      );

      // Out-of-range samples saturate at full positive swing.
      assign mag = (smp_w[gi] > 8'd127) ? 7'd127 : smp_w[gi][6:0];
      assign s_d = {1'b0, mag} - SMP_MID;
      assign p_d = env_scale(s_q, e_q);

      always_ff @(posedge clk12 or negedge n_reset) begin
        if (!n_reset) begin
          s_q <= 8'sd0;
          e_q <= 8'd0;
          p_q <= 8'sd0;
        end else begin
          s_q <= s_d;
          e_q <= env_w[gi];
          p_q <= p_d;
        end
      end

      assign p_w[gi] = p_q;
    end
  endgenerate

  logic signed [9:0] sum;
  logic [7:0]        dac_d, dac_q;

  assign sum = $signed({2'b00, DAC_MID}) + {{2{p_w[0][7]}}, p_w[0]} + {{2{p_w[1][7]}}, p_w[1]};

  always_comb begin
    dac_d = sum[7:0];
    if (sum < 10'sd0)        dac_d = 8'd0;
    else if (sum > 10'sd255) dac_d = 8'd255;
  end

  always_ff @(posedge clk12 or negedge n_reset) begin
    if (!n_reset) dac_q <= DAC_MID;
    else          dac_q <= dac_d;
  end

  assign dac_out = dac_q;
  assign env1    = env_w[0];
  assign env2    = env_w[1];
  assign st1     = st_w[0];
  assign st2     = st_w[1];

endmodule

// File: tb/tb_env_mixer2.sv
// Scenario bench for env_mixer2 with a fast tick; DAC words checked via a cycle-tagged queue.
module tb_env_mixer2;

  logic       clk12   = 1'b0;
  logic       n_reset = 1'b0;
  logic [5:0] note1   = 6'd0;
  logic [5:0] note2   = 6'd0;
  logic [7:0] smp1    = 8'd64;
  logic [7:0] smp2    = 8'd64;
  logic [7:0] dac_out, env1, env2;
  logic [1:0] st1, st2;

  int total   = 0;
  int bad     = 0;
  int cyc     = 0;
  int next_id = 0;

  typedef struct {
    int         cyc;
    logic [7:0] val;
    int         id;
  } exp_t;
  exp_t sb[$];

  env_mixer2 #(.TICK_DIV(4)) dut (
    .clk12   (clk12),
    .n_reset (n_reset),
    .note1   (note1),
    .note2   (note2),
    .smp1    (smp1),
    .smp2    (smp2),
    .dac_out (dac_out),
    .env1    (env1),
    .env2    (env2),
    .st1     (st1),
    .st2     (st2)
  );

  always #5 clk12 = ~clk12;

  always @(posedge clk12) cyc <= cyc + 1;

  always @(negedge clk12) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      if (e.cyc != cyc || dac_out !== e.val) begin
        bad++;
        $display("FAIL dac_sb#%0d: dac_out=%0d required=%0d (cycle %0d, due %0d)",
                 e.id, dac_out, e.val, cyc, e.cyc);
      end else begin
        $display("ok   dac_sb#%0d: dac_out=%0d at cycle %0d", e.id, dac_out, cyc);
      end
    end
  end

  function automatic int floor256(input int x);
    return (x >= 0) ? x / 256 : -((-x + 255) / 256);
  endfunction

  function automatic logic [7:0] model_dac(input int m1, input int e1, input int m2, input int e2);
    int a, b, v;
    a = (m1 > 127) ? 127 : m1;
    b = (m2 > 127) ? 127 : m2;
    v = 128 + floor256((a - 64) * e1) + floor256((b - 64) * e2);
    if (v < 0)   v = 0;
    if (v > 255) v = 255;
    return v[7:0];
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk12);
  endtask

  task automatic push_dac(input int delay, input logic [7:0] v);
    exp_t e;
    e.cyc = cyc + delay;
    e.val = v;
    e.id  = next_id;
    next_id++;
    sb.push_back(e);
  endtask

  task automatic wait_env1_change(input logic [7:0] prev, input int bound);
    for (int i = 0; i < bound; i++) begin
      step(1);
      if (env1 != prev) return;
    end
    total++;
    bad++;
    $display("FAIL env1_timeout: env1=%0d still after %0d cycles, required a change", env1, bound);
  endtask

  task automatic test_reset();
    step(2);
    total++;
    if (dac_out !== 8'd128 || env1 !== 8'd0 || env2 !== 8'd0 || st1 !== 2'd0 || st2 !== 2'd0) begin
      bad++;
      $display("FAIL reset_init: dac=%0d env1=%0d env2=%0d st1=%0d st2=%0d required 128/0/0/0/0",
               dac_out, env1, env2, st1, st2);
    end
    n_reset = 1'b1;
    note1   = 6'd5;
    smp1    = 8'd127;
    step(20);
    #2 n_reset = 1'b0;
    #1;
    total++;
    if (dac_out !== 8'd128 || env1 !== 8'd0 || st1 !== 2'd0 || st2 !== 2'd0) begin
      bad++;
      $display("FAIL reset_async: dac=%0d env1=%0d st1=%0d st2=%0d required 128/0/0/0",
               dac_out, env1, st1, st2);
    end
    step(1);
    n_reset = 1'b1;
    step(3);
    total++;
    if (env1 !== 8'd0 || st1 !== 2'd1) begin
      bad++;
      $display("FAIL reset_pre_tick: env1=%0d st1=%0d required 0/1", env1, st1);
    end
    step(1);
    total++;
    if (env1 !== 8'd8) begin
      bad++;
      $display("FAIL reset_first_tick: env1=%0d required 8", env1);
    end
  endtask

  task automatic test_attack();
    for (int k = 2; k <= 32; k++) begin
      logic [7:0] ee;
      logic [1:0] es;
      ee = (8 * k > 255) ? 8'd255 : 8'(8 * k);
      es = (k == 32) ? 2'd2 : 2'd1;
      step(4);
      total++;
      if (env1 !== ee || st1 !== es) begin
        bad++;
        $display("FAIL attack_tick%0d: env1=%0d st1=%0d required %0d/%0d", k, env1, st1, ee, es);
      end
    end
    total++;
    if (env2 !== 8'd0 || st2 !== 2'd0) begin
      bad++;
      $display("FAIL attack_ch2_idle: env2=%0d st2=%0d required 0/0", env2, st2);
    end
    push_dac(3, 8'd190);
  endtask

  task automatic test_decay();
    for (int k = 1; k <= 95; k++) begin
      logic [7:0] ee;
      logic [1:0] es;
      ee = 8'(255 - k);
      es = (k == 95) ? 2'd3 : 2'd2;
      step(4);
      total++;
      if (env1 !== ee || st1 !== es) begin
        bad++;
        $display("FAIL decay_tick%0d: env1=%0d st1=%0d required %0d/%0d", k, env1, st1, ee, es);
      end
    end
    push_dac(3, 8'd167);
    step(8);
    total++;
    if (env1 !== 8'd160 || st1 !== 2'd3) begin
      bad++;
      $display("FAIL sustain_hold: env1=%0d st1=%0d required 160/3", env1, st1);
    end
  endtask

  task automatic test_retrigger();
    note1 = 6'd5;
    step(8);
    total++;
    if (env1 !== 8'd160 || st1 !== 2'd3) begin
      bad++;
      $display("FAIL same_note: env1=%0d st1=%0d required 160/3", env1, st1);
    end
    note1 = 6'd7;
    step(1);
    total++;
    if (env1 !== 8'd160 || st1 !== 2'd1) begin
      bad++;
      $display("FAIL retrigger: env1=%0d st1=%0d required 160/1", env1, st1);
    end
    for (int k = 1; k <= 12; k++) begin
      logic [7:0] ee;
      ee = (160 + 8 * k > 255) ? 8'd255 : 8'(160 + 8 * k);
      wait_env1_change(env1, 6);
      total++;
      if (env1 !== ee) begin
        bad++;
        $display("FAIL retrig_tick%0d: env1=%0d required %0d", k, env1, ee);
      end
    end
    total++;
    if (st1 !== 2'd2) begin
      bad++;
      $display("FAIL retrig_decay: st1=%0d required 2", st1);
    end
  endtask

  task automatic test_mute();
    note1 = 6'd0;
    step(2);
    note1 = 6'd5;
    for (int k = 1; k <= 8; k++) begin
      wait_env1_change(env1, 6);
      total++;
      if (env1 !== 8'(8 * k)) begin
        bad++;
        $display("FAIL mute_ramp%0d: env1=%0d required %0d", k, env1, 8 * k);
      end
    end
    note1 = 6'd0;
    smp1  = 8'd0;
    step(1);
    total++;
    if (env1 !== 8'd0 || st1 !== 2'd0) begin
      bad++;
      $display("FAIL mute_edge: env1=%0d st1=%0d required 0/0", env1, st1);
    end
    push_dac(2, model_dac(0, 64, 64, 0));
    push_dac(3, 8'd128);
    step(5);
  endtask

  task automatic test_mix_extremes();
    int n;
    note1 = 6'd0;
    note2 = 6'd0;
    smp1  = 8'd64;
    smp2  = 8'd64;
    step(2);
    note1 = 6'd5;
    note2 = 6'd9;
    n = 0;
    while (env1 !== 8'd255 && n < 200) begin
      step(1);
      n++;
    end
    total++;
    if (env1 !== 8'd255 || env2 !== 8'd255) begin
      bad++;
      $display("FAIL mix_full_env: env1=%0d env2=%0d required 255/255", env1, env2);
    end
    smp1 = 8'd0;   smp2 = 8'd0;   push_dac(3, 8'd0);   step(1);
    smp1 = 8'd127; smp2 = 8'd127; push_dac(3, 8'd252); step(1);
    smp1 = 8'd0;   smp2 = 8'd127; push_dac(3, 8'd126); step(1);
    smp1 = 8'd200; smp2 = 8'd127; push_dac(3, model_dac(200, 255, 127, 255)); step(1);
    smp1 = 8'd64;  smp2 = 8'd64;
    step(6);
  endtask

  initial begin
    test_reset();
    test_attack();
    test_decay();
    test_retrigger();
    test_mute();
    test_mix_extremes();
    step(4);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/env_mixer2.md
Name: env_mixer2

Overview:
- Sits between the two note sine generators and the sigma-delta DAC. Applies a per-channel attack/decay/sustain amplitude envelope to each 8-bit unipolar sine sample. Mixes the two scaled channels into one 8-bit unipolar word for the DAC.
- Envelopes are keyed by the per-channel 6-bit note codes latched from the CPU speaker byte.
- The block replaces the plain averaging adder in front of the DAC.

Parameters:
- TICK_DIV, 1200, clk12 cycles per envelope tick (10 kHz at 12 MHz); legal range 2..65535.
- ATTACK_STEP, 8, envelope increment per tick in ATTACK.
- DECAY_STEP, 1, envelope decrement per tick in DECAY.
- SUSTAIN_LVL, 160, envelope level held in SUSTAIN; must be < 255.

Ports:
- clk12  in  1  system clock, 12 MHz.
- n_reset  in  1  asynchronous, active-low reset.
- note1  in  6  channel-1 note code; 0 = silent.
- note2  in  6  channel-2 note code; 0 = silent.
- smp1  in  8  channel-1 sine sample, 0..127, midpoint 64.
- smp2  in  8  channel-2 sine sample, 0..127, midpoint 64.
- dac_out  out  8  mixed unipolar sample for the DAC, midpoint 128.
- env1  out  8  channel-1 envelope level, 0..255.
- env2  out  8  channel-2 envelope level, 0..255.
- st1  out  2  channel-1 envelope state.
- st2  out  2  channel-2 envelope state.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - dac_out = 128; env1 = env2 = 0; st1 = st2 = IDLE.
  - Tick counter = 0; note history registers = 0; all pipeline registers are set so they produce 128.
- Tick generator:
  - Shared counter runs 0..TICK_DIV-1 and wraps.
  - tick is high for one clk12 cycle when count == TICK_DIV-1.
- Per-channel state machine. State encoding: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3.
  - Note history register note_q is updated with note every cycle.
  - Trigger: note != note_q and note != 0. Next state is ATTACK; env keeps its current value (retrigger does not restart from 0).
  - A repeated identical nonzero note does not retrigger.
  - Mute: note == 0. Next state is IDLE and env = 0 on the same edge (hard mute).
  - ATTACK on tick: env = min(env + ATTACK_STEP, 255). On reaching 255, go to DECAY.
  - DECAY on tick: env = max(env - DECAY_STEP, SUSTAIN_LVL). On reaching SUSTAIN_LVL, go to SUSTAIN.
  - SUSTAIN: env holds.
  - IDLE: env holds 0.
  - Priority: mute > trigger > tick update. A trigger coinciding with a tick changes state only; no env step that cycle.
- Datapath pipeline, latency 3 clk12 cycles from smp/env to dac_out:
  - S1: register s = smp - 64, signed 8-bit, range -64..63. Register the env value.
  - S2: p = (s * env) >>> 8. Signed 17-bit product, arithmetic shift (floor), range -64..62.
  - S3: dac_out = 128 + p1 + p2, 9-bit signed sum. Clamp to 0..255; unreachable with legal inputs, but required.
- smp inputs above 127 are out of contract. They are treated as 127 after clamping in S1.
- dac_out updates every clk12 cycle; there is no handshake.

Decomposition:
- Shared package holds:
  - Envelope state typedef (IDLE/ATTACK/DECAY/SUSTAIN, 2-bit).
  - Sample midpoint constants: SMP_MID = 64, DAC_MID = 128.
  - Default envelope constants.
- One sub-module, env_gen, instantiated twice:
  - Inputs: clk12, n_reset, note, tick.
  - Outputs: env, state.
- Tick counter, pipeline and mixer live in env_mixer2.

Test Plan (bench overrides TICK_DIV=4):
- Reset: assert n_reset low mid-run. Immediately dac_out = 128, env1 = env2 = 0, st = IDLE. After release, the first tick arrives 4 cycles later.
- Attack/saturation: note1 0→5, smp1 = 127, smp2 = 64.
  - env1 goes 8, 16, ... 248, then 255 on the 32nd tick; st1 goes to DECAY.
  - 3 cycles later dac_out = 128 + floor(63*255/256) = 190.
- Decay/sustain: continue the previous scenario. env1 falls by 1 per tick and reaches 160 after 95 ticks; st1 = SUSTAIN and holds. dac_out = 128 + floor(63*160/256) = 167.
- Retrigger/no-retrigger:
  - note1 5→5 in SUSTAIN: no change.
  - note1 5→7: ATTACK from 160; 255 on the 12th tick (160 + 88 = 248, then saturate).
- Mute mid-attack: note1 →0 while env1 = 64. Next edge env1 = 0 and st1 = IDLE; dac_out = 128 three cycles later, with smp1 held at 0.
- Mix extremes, both env = 255:
  - smp1 = smp2 = 0: dac_out = 0.
  - smp1 = smp2 = 127: dac_out = 252.
  - smp1 = 0, smp2 = 127: dac_out = 126.
